map_ss_seq: RTL and testbench
=============================

Name: map_ss_seq

Overview:
- Save-state sequencer for mapper register files that expose the ss_act/ss_we/ss_addr/ss_rdat port: bank registers, bank select, mirroring/RAM control, the extra register, IRQ state and map_idx.
- Walks ss_addr 0..SS_LEN-1 and moves one byte per address between the mapper and a byte-wide state memory over a req/ack handshake.
- SAVE reads the mapper and writes memory; LOAD reads memory and writes the mapper.
- Sits between the mapper instance and the system memory arbiter.

Parameters:
- SS_LEN, 128: number of state bytes walked; legal 1..256.
- MEM_BASE, 16'h0000: state-memory address of byte 0.

Ports:
- m2  in  1  system clock; all state updates on the falling edge of m2.
- map_rst  in  1  synchronous active-high reset, sampled on the falling edge of m2.
- start  in  1  begin operation; accepted only in IDLE.
- op  in  1  0 = SAVE, 1 = LOAD; sampled with start.
- abort  in  1  cancel the running operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an operation is cancelled.
- ss_act  out  1  mapper save-state mode; high for the whole of busy.
- ss_we  out  1  mapper state write strobe.
- ss_addr  out  8  mapper state address.
- ss_wdat  out  8  data to the mapper (drives cpu_dat while ss_act).
- ss_rdat  in  8  mapper state read data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  16  MEM_BASE + idx.
- mem_wdat  out  8  write data.
- mem_rdat  in  8  read data; valid in the ack cycle.
- mem_ack  in  1  request completed; sampled only while mem_req=1.
- csum  out  8  running checksum (see Optional Feature).

Behaviour:
- Reset: map_rst wins over all other inputs and forces state IDLE, idx=0 and data=0.
  - Every output is 0 after reset, including ss_addr, mem_addr, ss_wdat and mem_wdat.
  - Reset mid-operation abandons any outstanding request without pulsing done or aborted.
- State machine: IDLE, S_RD, S_WR, L_RD, L_WR, FIN.
- IDLE:
  - start=1 moves to S_RD if op=0, or L_RD if op=1; idx=0, busy=1 and ss_act=1 from the next cycle.
  - start while busy is ignored.
  - mem_ack in IDLE is ignored.
- SAVE path:
  - S_RD (1 cycle): ss_addr=idx, ss_we=0; latch data<=ss_rdat at the end of the cycle; go to S_WR.
  - S_WR: mem_req=1, mem_we=1, mem_wdat=data, mem_addr=MEM_BASE+idx.
  - S_WR holds until mem_ack=1, then goes to FIN if idx==SS_LEN-1, else idx++ and back to S_RD.
  - Per-byte latency is 2 cycles minimum (ack in the first S_WR cycle).
- LOAD path:
  - L_RD: mem_req=1, mem_we=0, mem_addr=MEM_BASE+idx; on mem_ack latch data<=mem_rdat and go to L_WR.
  - L_WR (1 cycle): ss_addr=idx, ss_wdat=data, ss_we=1; then go to FIN if idx==SS_LEN-1, else idx++ and back to L_RD.
- FIN (1 cycle): done=1, busy=0, ss_act=0; then IDLE.
  - Total SAVE with single-cycle acks is 2*SS_LEN+1 cycles from the cycle after start to done.
- Request rules:
  - mem_req and mem_addr stay stable until ack.
  - mem_req drops in the cycle after ack.
  - Back-to-back requests always have at least one cycle of mem_req=0 between them (the ss cycle).
- abort:
  - In any busy state, abort moves to IDLE on the next edge and pulses aborted=1 for one cycle; busy, ss_act and mem_req all drop.
  - abort and mem_ack in the same cycle: abort wins and the byte is not counted.
  - abort in IDLE or FIN is ignored; done still pulses in FIN.
  - abort and start together in IDLE: start wins and abort is ignored.
- ss_we is never high outside L_WR; mem_req is never high outside S_WR and L_RD.
- idx is 8 bits; with SS_LEN=256 the terminal index is 255 and idx never wraps.

Optional Feature:
- Macro: MAP_SS_CSUM_EN.
- When defined:
  - csum clears to 0 on start acceptance.
  - csum <= csum + byte (mod 256) for each transferred byte: the ss_rdat latched in S_RD for SAVE, the mem_rdat latched on ack for LOAD.
  - csum holds its value after done or abort and is reset by map_rst.
- When not defined: csum is constant 0 and no adder is built.

Test Plan:
- SAVE, SS_LEN=4, MEM_BASE=16'h1000, mapper returns 8'h10+addr, mem_ack immediate → writes (1000,10),(1001,11),(1002,12),(1003,13); done pulses at cycle 9 after start; csum=8'h46 when enabled.
- LOAD, SS_LEN=3, mem_rdat=A5,5A,FF with 3-cycle ack latency → ss_we pulses at ss_addr 0,1,2 with ss_wdat A5,5A,FF; ss_act high throughout; done once; csum=8'hFE when enabled.
- Abort during the second S_WR wait, with mem_ack asserted in the same cycle → aborted=1 for 1 cycle; busy=0 and mem_req=0 next cycle; done never asserts.
- map_rst asserted during L_RD → all outputs 0 next cycle; a following start with op=0 begins at ss_addr=0.
- start re-asserted while busy, and mem_ack driven in IDLE → no change in sequence or count.
- SS_LEN=256 SAVE → last write at MEM_BASE+255, no idx wrap, exactly 256 mem writes, done once.

Source files
------------

// File: rtl/map_ss_seq.sv
// Save-state sequencer: walks ss_addr 0..SS_LEN-1, moving one byte per address between mapper and state memory.
// Optional running checksum on csum when MAP_SS_CSUM_EN is defined.
module map_ss_seq #(
    parameter int          SS_LEN   = 128,
    parameter logic [15:0] MEM_BASE = 16'h0000
) (
    input  logic        m2,
    input  logic        map_rst,
    input  logic        start,
    input  logic        op,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        ss_act,
    output logic        ss_we,
    output logic [7:0]  ss_addr,
    output logic [7:0]  ss_wdat,
    input  logic [7:0]  ss_rdat,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdat,
    input  logic [7:0]  mem_rdat,
    input  logic        mem_ack,
    output logic [7:0]  csum
);

    typedef enum logic [2:0] {IDLE, S_RD, S_WR, L_RD, L_WR, FIN} state_t;

    localparam logic [7:0] LAST_IDX = 8'(SS_LEN - 1);

    state_t     state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic [7:0] data, data_nxt;
    logic       aborted_q, aborted_nxt;
    logic       start_acc;
    logic       byte_vld;
    logic [7:0] byte_val;

    always_ff @(negedge m2) begin
        if (map_rst) begin
            state     <= IDLE;
            idx       <= 8'h00;
            data      <= 8'h00;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            data      <= data_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    // Abort takes priority over every other input in the busy states, including mem_ack.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        data_nxt    = data;
        aborted_nxt = 1'b0;
        start_acc   = 1'b0;
        byte_vld    = 1'b0;
        byte_val    = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    idx_nxt   = 8'h00;
                    state_nxt = op ? L_RD : S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end else begin
                    data_nxt  = ss_rdat;
                    byte_vld  = 1'b1;
                    byte_val  = ss_rdat;
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end else if (mem_ack) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = S_RD;
                    end
                end
            end
            L_RD: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end else if (mem_ack) begin
                    data_nxt  = mem_rdat;
                    byte_vld  = 1'b1;
                    byte_val  = mem_rdat;
                    state_nxt = L_WR;
                end
            end
            L_WR: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end else if (idx == LAST_IDX) begin
                    state_nxt = FIN;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = L_RD;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data outputs are gated so that IDLE presents all zeros.
    always_comb begin
        busy     = (state == S_RD) || (state == S_WR) || (state == L_RD) || (state == L_WR);
        ss_act   = busy;
        done     = (state == FIN);
        aborted  = aborted_q;
        ss_we    = (state == L_WR);
        ss_addr  = busy ? idx : 8'h00;
        ss_wdat  = ss_we ? data : 8'h00;
        mem_req  = (state == S_WR) || (state == L_RD);
        mem_we   = (state == S_WR);
        mem_addr = mem_req ? (MEM_BASE + {8'h00, idx}) : 16'h0000;
        mem_wdat = mem_we ? data : 8'h00;
    end

`ifdef MAP_SS_CSUM_EN
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    logic [7:0] csum_q;

    always_ff @(negedge m2) begin
        if (map_rst) begin
            csum_q <= 8'h00;
        end else if (start_acc) begin
            csum_q <= 8'h00;
        end else if (byte_vld) begin
            csum_q <= csum_add(csum_q, byte_val);
        end
    end

    assign csum = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^{start_acc, byte_vld, byte_val};
    assign csum        = 8'h00;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
// Scoreboard bench for map_ss_seq: two instances (SS_LEN=4 and SS_LEN=256), random data and ack latencies.
`timescale 1ns/1ps
module tb_map_ss_seq;

    localparam int          LEN0  = 4;
    localparam logic [15:0] BASE0 = 16'h1000;
    localparam int          LEN1  = 256;
    localparam logic [15:0] BASE1 = 16'h2000;

    logic m2 = 1'b0;
    always #5 m2 = ~m2;
    logic map_rst = 1'b1;

    logic        start = 0, op = 0, abort = 0;
    logic        busy, done, aborted, ss_act, ss_we, mem_req, mem_we;
    logic [7:0]  ss_addr, ss_wdat, ss_rdat, mem_wdat, csum;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdat = 8'h00;
    logic        mem_ack = 1'b0;

    logic        b_start = 0, b_op = 0, b_abort = 0;
    logic        b_busy, b_done, b_aborted, b_ss_act, b_ss_we, b_mem_req, b_mem_we;
    logic [7:0]  b_ss_addr, b_ss_wdat, b_ss_rdat, b_mem_wdat, b_csum;
    logic [15:0] b_mem_addr;
    logic [7:0]  b_mem_rdat = 8'h00;
    logic        b_mem_ack = 1'b0;

    logic [7:0] map0 [256];
    logic [7:0] map1 [256];
    logic [7:0] img0 [256];
    int         lat0 = 0, lat1 = 0, w0 = 0, w1 = 0;
    logic       stray0 = 1'b0;

    assign ss_rdat   = map0[ss_addr];
    assign b_ss_rdat = map1[b_ss_addr];

    map_ss_seq #(.SS_LEN(LEN0), .MEM_BASE(BASE0)) u_dut (
        .m2(m2), .map_rst(map_rst), .start(start), .op(op), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat), .mem_ack(mem_ack), .csum(csum));

    map_ss_seq #(.SS_LEN(LEN1), .MEM_BASE(BASE1)) u_big (
        .m2(m2), .map_rst(map_rst), .start(b_start), .op(b_op), .abort(b_abort),
        .busy(b_busy), .done(b_done), .aborted(b_aborted), .ss_act(b_ss_act), .ss_we(b_ss_we),
        .ss_addr(b_ss_addr), .ss_wdat(b_ss_wdat), .ss_rdat(b_ss_rdat),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdat(b_mem_wdat),
        .mem_rdat(b_mem_rdat), .mem_ack(b_mem_ack), .csum(b_csum));

    // Memory responders: ack after lat extra cycles of mem_req.
    always @(negedge m2) begin
        #1;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (w0 >= lat0) begin mem_ack = 1'b1; w0 = 0; end
            else w0++;
        end else begin
            w0 = 0;
            mem_ack = stray0;
        end
        mem_rdat = img0[8'(mem_addr - BASE0)];
    end

    always @(negedge m2) begin
        #1;
        b_mem_ack = 1'b0;
        if (b_mem_req) begin
            if (w1 >= lat1) begin b_mem_ack = 1'b1; w1 = 0; end
            else w1++;
        end else w1 = 0;
    end

    int checks = 0, failures = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Event word: {kind, 4'b0, addr16, data8}. 1=mem write, 2=mem read, 3=ss write, 4=done, 5=aborted.
    function automatic logic [31:0] ev_of(input logic mreq, mwe, mack, ab,
                                          input logic [15:0] ma, input logic [7:0] mwd, mrd,
                                          input logic ssw, input logic [7:0] sa, sd,
                                          input logic dn, abd);
        if (mreq && mack && !ab) return mwe ? {4'd1, 4'd0, ma, mwd} : {4'd2, 4'd0, ma, mrd};
        if (ssw) return {4'd3, 4'd0, 8'h00, sa, sd};
        if (dn)  return {4'd4, 28'd0};
        if (abd) return {4'd5, 28'd0};
        return 32'd0;
    endfunction

    function automatic logic [7:0] cs_exp(input logic [7:0] s);
`ifdef MAP_SS_CSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    logic [31:0] e0, x0, e1, x1;
    always @(posedge m2) begin
        #2;
        if (!map_rst) begin
            e0 = ev_of(mem_req, mem_we, mem_ack, abort, mem_addr, mem_wdat, mem_rdat,
                       ss_we, ss_addr, ss_wdat, done, aborted);
            if (e0 != 0) begin
                if (q0.size() == 0) chk("ch0_extra_event", 64'(e0), 64'd0);
                else begin x0 = q0.pop_front(); chk("ch0_event", 64'(e0), 64'(x0)); end
            end
            chk("ch0_ss_act", 64'(ss_act), 64'(busy));
            e1 = ev_of(b_mem_req, b_mem_we, b_mem_ack, b_abort, b_mem_addr, b_mem_wdat, b_mem_rdat,
                       b_ss_we, b_ss_addr, b_ss_wdat, b_done, b_aborted);
            if (e1 != 0) begin
                if (q1.size() == 0) chk("ch1_extra_event", 64'(e1), 64'd0);
                else begin x1 = q1.pop_front(); chk("ch1_event", 64'(e1), 64'(x1)); end
            end
        end
    end

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic exp_save(input int ch, input int n, output logic [7:0] s);
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (ch == 0) begin q0.push_back({4'd1, 4'd0, BASE0 + 16'(i), map0[i]}); s += map0[i]; end
            else begin q1.push_back({4'd1, 4'd0, BASE1 + 16'(i), map1[i]}); s += map1[i]; end
        end
        if (ch == 0) q0.push_back({4'd4, 28'd0});
        else q1.push_back({4'd4, 28'd0});
    endtask

    task automatic exp_load(input int n, output logic [7:0] s);
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            q0.push_back({4'd2, 4'd0, BASE0 + 16'(i), img0[i]});
            q0.push_back({4'd3, 4'd0, 8'h00, 8'(i), img0[i]});
            s += img0[i];
        end
        q0.push_back({4'd4, 28'd0});
    endtask

    // Starts an operation and waits (bounded) for done; cyc counts from the cycle after start.
    task automatic run(input int ch, input logic o, input bit with_abort, input bit spam,
                       output int cyc, output logic [8:0] first);
        if (ch == 0) begin start = 1'b1; op = o; abort = with_abort; end
        else begin b_start = 1'b1; b_op = o; end
        tick();
        start = 1'b0; abort = 1'b0; b_start = 1'b0;
        cyc = 1;
        first = (ch == 0) ? {busy, ss_addr} : {b_busy, b_ss_addr};
        while (!((ch == 0) ? done : b_done) && cyc < 3000) begin
            if (spam && ch == 0) begin
                start = busy && ($urandom_range(1) == 1);
                op    = 1'($urandom_range(1));
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 3000) chk("done_timeout", 64'(cyc), 64'd0);
    endtask

    int         cyc, n, lat;
    logic [7:0] s;
    logic [8:0] first;
    logic       o;

    initial begin
        for (int i = 0; i < 256; i++) begin map0[i] = 8'h00; map1[i] = 8'h00; img0[i] = 8'h00; end
        repeat (3) tick();
        chk("rst_ch0", 64'({busy, done, aborted, ss_act, ss_we, ss_addr, ss_wdat, mem_req, mem_we,
                            mem_addr, mem_wdat, csum}), 64'd0);
        chk("rst_ch1", 64'({b_busy, b_done, b_aborted, b_ss_act, b_ss_we, b_ss_addr, b_ss_wdat,
                            b_mem_req, b_mem_we, b_mem_addr, b_mem_wdat, b_csum}), 64'd0);
        map_rst = 1'b0;
        tick();

        // Stray ack and abort in IDLE do nothing.
        stray0 = 1'b1; abort = 1'b1;
        repeat (4) tick();
        chk("idle_noise_busy", 64'({busy, aborted}), 64'd0);
        stray0 = 1'b0; abort = 1'b0;
        tick();

        // Directed SAVE: mapper bytes 10+addr, immediate ack.
        for (int i = 0; i < 256; i++) map0[i] = 8'h10 + 8'(i);
        lat0 = 0;
        exp_save(0, LEN0, s);
        run(0, 1'b0, 1'b0, 1'b0, cyc, first);
        chk("save_done_cycle", 64'(cyc), 64'd9);
        chk("save_csum", 64'(csum), 64'(cs_exp(8'h46)));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("fin_abort_ignored", 64'({aborted, busy}), 64'd0);
        tick();

        // Directed LOAD: A5,5A,FF,... with ack in the third request cycle.
        img0[0] = 8'hA5; img0[1] = 8'h5A; img0[2] = 8'hFF; img0[3] = 8'h3C;
        lat0 = 2;
        exp_load(LEN0, s);
        run(0, 1'b1, 1'b0, 1'b0, cyc, first);
        chk("load_done_cycle", 64'(cyc), 64'(LEN0 * 4 + 1));
        chk("load_csum", 64'(csum), 64'(cs_exp(s)));
        tick();

        // Abort together with mem_ack during the second S_WR.
        for (int i = 0; i < 256; i++) map0[i] = 8'($urandom);
        lat0 = 0;
        q0.push_back({4'd1, 4'd0, BASE0, map0[0]});
        q0.push_back({4'd5, 28'd0});
        start = 1'b1; op = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (!(mem_req && mem_we && mem_addr == BASE0 + 16'd1) && n < 50) begin tick(); n++; end
        chk("abort_reach_wr", 64'(n < 50), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", 64'({aborted, busy, mem_req, ss_act, done}), 64'b10000);
        tick();
        chk("abort_one_cycle", 64'({aborted, busy, done}), 64'd0);
        tick();

        // Reset during L_RD, then a clean SAVE restarts at address 0.
        lat0 = 3;
        start = 1'b1; op = 1'b1;
        tick();
        start = 1'b0;
        chk("lrd_req", 64'({mem_req, mem_we}), 64'b10);
        map_rst = 1'b1;
        tick();
        chk("rst_mid_outs", 64'({busy, done, aborted, ss_act, ss_we, ss_addr, ss_wdat, mem_req, mem_we,
                                 mem_addr, mem_wdat, csum}), 64'd0);
        q0.delete();
        map_rst = 1'b0;
        tick();
        lat0 = 1;
        exp_save(0, LEN0, s);
        run(0, 1'b0, 1'b0, 1'b0, cyc, first);
        chk("restart_first", 64'(first), 64'({1'b1, 8'h00}));
        chk("restart_cycles", 64'(cyc), 64'(LEN0 * 3 + 1));
        chk("restart_csum", 64'(csum), 64'(cs_exp(s)));
        tick();

        // Random operations, start spammed while busy, abort raised alongside start.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 256; i++) begin map0[i] = 8'($urandom); img0[i] = 8'($urandom); end
            lat = $urandom_range(3);
            lat0 = lat;
            o = 1'($urandom_range(1));
            if (o) exp_load(LEN0, s);
            else exp_save(0, LEN0, s);
            run(0, o, 1'($urandom_range(1)), 1'b1, cyc, first);
            chk("rand_cycles", 64'(cyc), 64'(LEN0 * (lat + 2) + 1));
            chk("rand_csum", 64'(csum), 64'(cs_exp(s)));
            tick();
        end

        // SS_LEN=256: full walk, terminal index 255, no wrap.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) map1[i] = 8'($urandom);
            lat1 = k;
            exp_save(1, LEN1, s);
            run(1, 1'b0, 1'b0, 1'b0, cyc, first);
            chk("big_cycles", 64'(cyc), 64'(LEN1 * (k + 2) + 1));
            chk("big_csum", 64'(b_csum), 64'(cs_exp(s)));
            tick();
        end

        repeat (4) tick();
        chk("ch0_queue_empty", 64'(q0.size()), 64'd0);
        chk("ch1_queue_empty", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
